ap_ctrl_sequencer: RTL and testbench
====================================

# ap_ctrl_sequencer

Synthesizable stimulus-and-measurement stage placed directly upstream of an `ap_ctrl_hs` HLS kernel such as `half_adder`. It issues a commanded number of transactions over the `ap_start`/`ap_ready`/`ap_done` handshake and tracks outstanding transactions. It also measures per-transaction latency. It raises `finish`, which the dataflow monitor's `finish` input consumes to end sampling and dump module status.

## Interface
- `CNT_W`, 16, width of transaction count and counters
- `TS_W`, 32, width of free-running cycle timestamp and latency values
- `DEPTH`, 4, maximum outstanding (accepted, not done) transactions; power of two ≥ 2
- `TIMEOUT`, 1024, watchdog limit in cycles (used only with watchdog compiled in)

Ports:
- `clock` in 1: single clock; all logic on posedge
- `reset` in 1: synchronous, active-high
- `cmd_valid` in 1: run request
- `cmd_ready` out 1: high in IDLE only
- `cmd_count` in CNT_W: number of transactions for the run
- `ap_start` out 1: kernel start
- `ap_ready` in 1: kernel accepted input
- `ap_done` in 1: kernel completed one transaction
- `finish` out 1: run complete, sticky
- `busy` out 1: run in progress
- `started_cnt` out CNT_W: accepted transactions this run
- `done_cnt` out CNT_W: completed transactions this run
- `last_lat`, `min_lat`, `max_lat` out TS_W: latency statistics
- `proto_err` out 1: sticky, `ap_done` with nothing outstanding
- `timeout_err` out 1: sticky watchdog flag

## Operation
- Transaction accept (`acc`) = `ap_start && ap_ready`.
- Free-running `ts` counter, TS_W bits, cleared by reset, wraps modulo 2^TS_W.
- States are IDLE, ISSUE and DRAIN.
- **IDLE:**
  - `cmd_ready`=1.
  - On `cmd_valid` with `cmd_count`≠0: clear `started_cnt`, `done_cnt`, `last_lat`, `max_lat` and `finish`; set `min_lat` to all-ones; latch the count; go to ISSUE.
  - On `cmd_valid` with `cmd_count`=0: set `finish`=1 and stay in IDLE.
- **ISSUE:**
  - `ap_start`=1 while outstanding < DEPTH, else 0.
  - Each `acc` pushes `ts` into the timestamp FIFO and increments `started_cnt`.
  - Go to DRAIN on the `acc` that makes `started_cnt` equal to the latched count.
- **DRAIN:**
  - `ap_start`=0.
  - Go to IDLE when `done_cnt` reaches the count, and set `finish`=1 on that transition.
- **On every `ap_done` with an entry available:**
  - Latency = `ts` − popped timestamp (modulo subtraction, so `ts` wrap is harmless).
  - Update `last_lat`, `min_lat` and `max_lat`; increment `done_cnt`.
- **Same-cycle accept and done with an empty FIFO:** bypass the FIFO; latency = 0. This is the combinational `half_adder` case.
- **Simultaneous push and pop on a non-empty FIFO:** both happen; occupancy is unchanged.
- **`ap_done` with the FIFO empty and no same-cycle `acc`:** set `proto_err`; counters unchanged.
- `busy` = (state ≠ IDLE).
- `finish` stays high in IDLE until the next accepted command.

## Timing
- Reset values: state IDLE; `ap_start`=0, `cmd_ready`=1, `finish`=0, `busy`=0; all counters and latencies 0 except `min_lat`=all-ones; error flags 0; FIFO empty.
- `cmd_valid` accepted in cycle N: `ap_start` is high in N+1.
- `ap_start` falls in the cycle after the final `acc`.
- `finish` and `busy`=0 are registered and appear one cycle after the final `ap_done`.
- Reset mid-run aborts immediately: FIFO flushed, statistics lost, `finish` stays 0.
- Full FIFO with a same-cycle `ap_done`: `ap_start` is computed from registered occupancy and stays 0 that cycle.

## Configuration
- `AP_SEQ_WATCHDOG_EN` defined:
  - A cycle counter runs while outstanding > 0 and clears on every `acc` or `ap_done`.
  - When it reaches TIMEOUT: set `timeout_err`, flush the FIFO, drop `ap_start`, go to IDLE and set `finish`=1.
- Undefined: no watchdog logic; the `timeout_err` port stays present and is tied 0.

## Structure
- Package `ap_seq_pkg` holds:
  - the state enum `ap_seq_state_e` (IDLE, ISSUE, DRAIN)
  - default width constants
  - the `LAT_INIT_MIN` all-ones constant
- Sub-module `ap_seq_ts_fifo` is a synchronous FIFO with DEPTH entries of TS_W bits. It provides push, pop, count, empty and full outputs, and a synchronous flush.

## Test plan
- Fixed-latency kernel model (`ap_ready`=1, `ap_done` 3 cycles after accept), `cmd_count`=5:
  - `started_cnt`=`done_cnt`=5
  - `last_lat`=`min_lat`=`max_lat`=3
  - `finish` high one cycle after the 5th done
- Combinational kernel (`ap_done`=`ap_ready`=`ap_start`), `cmd_count`=4: all latencies 0, `proto_err`=0.
- Pipelined kernel (II=1, latency 10), DEPTH=4, `cmd_count`=8:
  - `ap_start` throttles at 4 outstanding
  - all latencies 10, `done_cnt`=8
- `ap_done` pulsed in IDLE: `proto_err`=1 sticky; counters stay 0.
- `cmd_count`=0: `finish`=1 next cycle, `ap_start` never asserted.
- With `AP_SEQ_WATCHDOG_EN`, TIMEOUT=16, kernel never asserts `ap_done`, `cmd_count`=2: `timeout_err`=1 and `finish`=1, state IDLE, `done_cnt`=0.

Source files
------------

// File: rtl/ap_seq_pkg.sv
// Shared state encoding, default widths and statistics reset constant for ap_ctrl_sequencer.
package ap_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } ap_seq_state_e;

    localparam int DEF_CNT_W   = 16;
    localparam int DEF_TS_W    = 32;
    localparam int DEF_DEPTH   = 4;
    localparam int DEF_TIMEOUT = 1024;

    localparam logic [DEF_TS_W-1:0] LAT_INIT_MIN = '1;

endpackage

// File: rtl/ap_seq_ts_fifo.sv
// Synchronous timestamp FIFO holding the accept time of each outstanding transaction.
module ap_seq_ts_fifo #(
    parameter int DEPTH = 4,
    parameter int TS_W  = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [TS_W-1:0]          i_pushData,
    input  logic                     i_pop,
    output logic [TS_W-1:0]          o_popData,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_empty,
    output logic                     o_full
);
    localparam int AW = $clog2(DEPTH);

    logic [TS_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]   r_wrPtr;
    logic [AW-1:0]   r_rdPtr;
    logic [AW:0]     r_count;
    logic            w_doPush;
    logic            w_doPop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_count   = r_count;
    assign o_popData = r_mem[r_rdPtr];

    // A push into a full FIFO is only honoured when a pop frees a slot the same cycle.
    assign w_doPop  = i_pop && !o_empty;
    assign w_doPush = i_push && (!o_full || w_doPop);

    always_ff @(posedge clock) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= i_pushData;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || i_flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + AW'(1);
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + AW'(1);
            end
            r_count <= r_count + (AW+1)'(w_doPush) - (AW+1)'(w_doPop);
        end
    end

endmodule

// File: rtl/ap_ctrl_sequencer.sv
// Issues a commanded number of ap_ctrl_hs transactions and measures per-transaction latency.
// Optional watchdog compiled in with `define AP_SEQ_WATCHDOG_EN.
module ap_ctrl_sequencer
    import ap_seq_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int TS_W    = DEF_TS_W,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_count,
    output logic             ap_start,
    input  logic             ap_ready,
    input  logic             ap_done,
    output logic             finish,
    output logic             busy,
    output logic [CNT_W-1:0] started_cnt,
    output logic [CNT_W-1:0] done_cnt,
    output logic [TS_W-1:0]  last_lat,
    output logic [TS_W-1:0]  min_lat,
    output logic [TS_W-1:0]  max_lat,
    output logic             proto_err,
    output logic             timeout_err
);
    localparam int OCC_W = $clog2(DEPTH) + 1;

    ap_seq_state_e    r_state;
    ap_seq_state_e    w_stateNext;
    logic [TS_W-1:0]  r_ts;
    logic [TS_W-1:0]  r_lastLat;
    logic [TS_W-1:0]  r_minLat;
    logic [TS_W-1:0]  r_maxLat;
    logic [TS_W-1:0]  w_lat;
    logic [TS_W-1:0]  w_headTs;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_startedCnt;
    logic [CNT_W-1:0] r_doneCnt;
    logic [CNT_W-1:0] w_startedNext;
    logic [CNT_W-1:0] w_doneNext;
    logic             r_finish;
    logic             r_protoErr;
    logic             w_acc;
    logic             w_bypass;
    logic             w_push;
    logic             w_pop;
    logic             w_doneValid;
    logic             w_cmdAccept;
    logic             w_finishSet;
    logic             w_wdFire;
    logic             w_fifoEmpty;
    logic             w_fifoFull;
    logic [OCC_W-1:0] w_fifoCount;

    // Start is driven from registered occupancy so a same-cycle done cannot reopen a full window.
    assign ap_start = (r_state == ISSUE) && !w_fifoFull && !w_wdFire;
    assign w_acc    = ap_start && ap_ready;

    // Accept and done together on an empty FIFO is the zero-latency combinational kernel case.
    assign w_bypass    = w_acc && ap_done && w_fifoEmpty;
    assign w_push      = w_acc && !w_bypass;
    assign w_pop       = ap_done && !w_fifoEmpty;
    assign w_doneValid = w_pop || w_bypass;
    assign w_lat       = w_bypass ? '0 : (r_ts - w_headTs);

    assign w_startedNext = r_startedCnt + CNT_W'(w_acc);
    assign w_doneNext    = r_doneCnt + CNT_W'(w_doneValid);

    ap_seq_ts_fifo #(
        .DEPTH (DEPTH),
        .TS_W  (TS_W)
    ) u_tsFifo (
        .clock      (clock),
        .reset      (reset),
        .i_flush    (w_wdFire),
        .i_push     (w_push),
        .i_pushData (r_ts),
        .i_pop      (w_pop),
        .o_popData  (w_headTs),
        .o_count    (w_fifoCount),
        .o_empty    (w_fifoEmpty),
        .o_full     (w_fifoFull)
    );

    always_comb begin
        w_stateNext = r_state;
        w_cmdAccept = 1'b0;
        w_finishSet = 1'b0;
        case (r_state)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_count != '0) begin
                        w_cmdAccept = 1'b1;
                        w_stateNext = ISSUE;
                    end else begin
                        w_finishSet = 1'b1;
                    end
                end
            end
            ISSUE: begin
                // The last accept can also complete the run when the kernel answers in the same cycle.
                if (w_acc && (w_startedNext == r_count)) begin
                    if (w_doneNext == r_count) begin
                        w_stateNext = IDLE;
                        w_finishSet = 1'b1;
                    end else begin
                        w_stateNext = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (w_doneNext == r_count) begin
                    w_stateNext = IDLE;
                    w_finishSet = 1'b1;
                end
            end
            default: w_stateNext = IDLE;
        endcase
        if (w_wdFire) begin
            w_stateNext = IDLE;
            w_finishSet = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= IDLE;
            r_ts         <= '0;
            r_count      <= '0;
            r_startedCnt <= '0;
            r_doneCnt    <= '0;
            r_lastLat    <= '0;
            r_minLat     <= {TS_W{LAT_INIT_MIN[0]}};
            r_maxLat     <= '0;
            r_finish     <= 1'b0;
            r_protoErr   <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_ts    <= r_ts + TS_W'(1);
            if (w_cmdAccept) begin
                r_count      <= cmd_count;
                r_startedCnt <= '0;
                r_doneCnt    <= '0;
                r_lastLat    <= '0;
                r_minLat     <= {TS_W{LAT_INIT_MIN[0]}};
                r_maxLat     <= '0;
                r_finish     <= 1'b0;
            end else begin
                if (w_acc) begin
                    r_startedCnt <= w_startedNext;
                end
                if (w_doneValid) begin
                    r_doneCnt <= w_doneNext;
                    r_lastLat <= w_lat;
                    if (w_lat < r_minLat) begin
                        r_minLat <= w_lat;
                    end
                    if (w_lat > r_maxLat) begin
                        r_maxLat <= w_lat;
                    end
                end
                if (w_finishSet) begin
                    r_finish <= 1'b1;
                end
            end
            if (ap_done && w_fifoEmpty && !w_acc) begin
                r_protoErr <= 1'b1;
            end
        end
    end

`ifdef AP_SEQ_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] r_wdCnt;
    logic            r_timeoutErr;

    // Counts stalled cycles with work outstanding; any handshake activity restarts the count.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wdCnt      <= '0;
            r_timeoutErr <= 1'b0;
        end else if (w_wdFire) begin
            r_wdCnt      <= '0;
            r_timeoutErr <= 1'b1;
        end else if (w_acc || ap_done || (w_fifoCount == '0)) begin
            r_wdCnt <= '0;
        end else begin
            r_wdCnt <= r_wdCnt + WD_W'(1);
        end
    end

    assign w_wdFire    = (r_wdCnt == WD_W'(TIMEOUT));
    assign timeout_err = r_timeoutErr;
`else
    localparam int unusedTimeout = TIMEOUT;

    logic w_unusedCount;

    assign w_unusedCount = ^w_fifoCount;
    assign w_wdFire      = 1'b0;
    assign timeout_err   = 1'b0;
`endif

    assign cmd_ready   = (r_state == IDLE);
    assign busy        = (r_state != IDLE);
    assign finish      = r_finish;
    assign started_cnt = r_startedCnt;
    assign done_cnt    = r_doneCnt;
    assign last_lat    = r_lastLat;
    assign min_lat     = r_minLat;
    assign max_lat     = r_maxLat;
    assign proto_err   = r_protoErr;

endmodule

// File: tb/tb_ap_ctrl_sequencer.sv
// Directed self-checking bench for ap_ctrl_sequencer driving several kernel models.
module tb_ap_ctrl_sequencer;

    localparam int KM_FIXED  = 0;
    localparam int KM_COMB   = 1;
    localparam int KM_PIPE   = 2;
    localparam int KM_MANUAL = 3;
    localparam int KM_NEVER  = 4;

    logic        clock;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_count;
    logic        ap_start;
    logic        ap_ready;
    logic        ap_done;
    logic        finish;
    logic        busy;
    logic [15:0] started_cnt;
    logic [15:0] done_cnt;
    logic [31:0] last_lat;
    logic [31:0] min_lat;
    logic [31:0] max_lat;
    logic        proto_err;
    logic        timeout_err;

    int          kernelMode;
    logic        manualDone;
    logic [15:0] dline;

    int vectors;
    int miscompares;
    int accepts;
    int dones;
    int maxOut;
    int lastDone;
    int finCyc;
    logic startN1;

    ap_ctrl_sequencer #(
        .CNT_W   (16),
        .TS_W    (32),
        .DEPTH   (4),
        .TIMEOUT (16)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_count   (cmd_count),
        .ap_start    (ap_start),
        .ap_ready    (ap_ready),
        .ap_done     (ap_done),
        .finish      (finish),
        .busy        (busy),
        .started_cnt (started_cnt),
        .done_cnt    (done_cnt),
        .last_lat    (last_lat),
        .min_lat     (min_lat),
        .max_lat     (max_lat),
        .proto_err   (proto_err),
        .timeout_err (timeout_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Kernel model: delay line of accepts feeds fixed and pipelined completion.
    always @(posedge clock) begin
        if (reset) dline <= '0;
        else       dline <= {dline[14:0], ap_start && ap_ready};
    end

    always_comb begin
        ap_ready = (kernelMode == KM_COMB) ? ap_start : 1'b1;
        case (kernelMode)
            KM_FIXED:  ap_done = dline[2];
            KM_COMB:   ap_done = ap_start;
            KM_PIPE:   ap_done = dline[9];
            KM_MANUAL: ap_done = manualDone;
            default:   ap_done = 1'b0;
        endcase
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Runs one command and watches the handshake until finish with busy low, or the budget expires.
    task automatic applyStimulus(input int count, input int mode, input int budget);
        int outNow;
        repeat (16) @(negedge clock);
        kernelMode = mode;
        accepts = 0; dones = 0; maxOut = 0; lastDone = -1; finCyc = -1; outNow = 0;
        @(negedge clock);
        cmd_count = 16'(count);
        cmd_valid = 1'b1;
        @(negedge clock);
        cmd_valid = 1'b0;
        startN1 = ap_start;
        for (int cyc = 0; cyc < budget; cyc++) begin
            if (ap_start && ap_ready) begin accepts++; outNow++; end
            if (ap_done) begin dones++; outNow--; lastDone = cyc; end
            if (outNow > maxOut) maxOut = outNow;
            if (finish && !busy) begin finCyc = cyc; break; end
            @(negedge clock);
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL globalTimeout: simulation did not complete");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        vectors = 0; miscompares = 0;
        reset = 1'b1; cmd_valid = 1'b0; cmd_count = '0;
        kernelMode = KM_FIXED; manualDone = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;

        checkOutput("rstApStart",  ap_start,    0);
        checkOutput("rstCmdReady", cmd_ready,   1);
        checkOutput("rstFinish",   finish,      0);
        checkOutput("rstBusy",     busy,        0);
        checkOutput("rstStarted",  started_cnt, 0);
        checkOutput("rstDone",     done_cnt,    0);
        checkOutput("rstLastLat",  last_lat,    0);
        checkOutput("rstMinLat",   min_lat,     32'hFFFF_FFFF);
        checkOutput("rstMaxLat",   max_lat,     0);
        checkOutput("rstProto",    proto_err,   0);
        checkOutput("rstTimeout",  timeout_err, 0);

        $display("[TB] zero-count command");
        applyStimulus(0, KM_FIXED, 20);
        checkOutput("zeroFinCyc",   finCyc,    0);
        checkOutput("zeroAccepts",  accepts,   0);
        checkOutput("zeroCmdReady", cmd_ready, 1);

        $display("[TB] fixed latency 3, count 5");
        applyStimulus(5, KM_FIXED, 200);
        checkOutput("fixStartN1",  startN1,           1);
        checkOutput("fixFinSeen",  finCyc >= 0,       1);
        checkOutput("fixFinGap",   finCyc - lastDone, 1);
        checkOutput("fixStarted",  started_cnt,       5);
        checkOutput("fixDone",     done_cnt,          5);
        checkOutput("fixLastLat",  last_lat,          3);
        checkOutput("fixMinLat",   min_lat,           3);
        checkOutput("fixMaxLat",   max_lat,           3);
        checkOutput("fixProto",    proto_err,         0);

        $display("[TB] combinational kernel, count 4");
        applyStimulus(4, KM_COMB, 200);
        checkOutput("combFinSeen", finCyc >= 0,       1);
        checkOutput("combFinGap",  finCyc - lastDone, 1);
        checkOutput("combStarted", started_cnt,       4);
        checkOutput("combDone",    done_cnt,          4);
        checkOutput("combLastLat", last_lat,          0);
        checkOutput("combMinLat",  min_lat,           0);
        checkOutput("combMaxLat",  max_lat,           0);
        checkOutput("combProto",   proto_err,         0);

        $display("[TB] pipelined kernel II=1 latency 10, count 8");
        applyStimulus(8, KM_PIPE, 300);
        checkOutput("pipeFinSeen", finCyc >= 0, 1);
        checkOutput("pipeMaxOut",  maxOut,      4);
        checkOutput("pipeAccepts", accepts,     8);
        checkOutput("pipeStarted", started_cnt, 8);
        checkOutput("pipeDone",    done_cnt,    8);
        checkOutput("pipeLastLat", last_lat,    10);
        checkOutput("pipeMinLat",  min_lat,     10);
        checkOutput("pipeMaxLat",  max_lat,     10);
        checkOutput("pipeProto",   proto_err,   0);
        checkOutput("pipeTimeout", timeout_err, 0);

        $display("[TB] reset in the middle of a run");
        repeat (16) @(negedge clock);
        kernelMode = KM_FIXED;
        cmd_count = 16'd5;
        cmd_valid = 1'b1;
        @(negedge clock);
        cmd_valid = 1'b0;
        repeat (4) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checkOutput("midBusy",    busy,        0);
        checkOutput("midFinish",  finish,      0);
        checkOutput("midApStart", ap_start,    0);
        checkOutput("midStarted", started_cnt, 0);
        checkOutput("midMinLat",  min_lat,     32'hFFFF_FFFF);
        checkOutput("midProto",   proto_err,   0);

        $display("[TB] ap_done pulsed while idle");
        kernelMode = KM_MANUAL;
        @(negedge clock);
        manualDone = 1'b1;
        @(negedge clock);
        manualDone = 1'b0;
        checkOutput("idleProto",   proto_err,   1);
        checkOutput("idleDone",    done_cnt,    0);
        checkOutput("idleStarted", started_cnt, 0);
        checkOutput("idleLastLat", last_lat,    0);
        @(negedge clock);
        checkOutput("idleProtoSticky", proto_err, 1);

`ifdef AP_SEQ_WATCHDOG_EN
        $display("[TB] watchdog with silent kernel, count 2");
        applyStimulus(2, KM_NEVER, 100);
        checkOutput("wdFinSeen",  finCyc >= 0, 1);
        checkOutput("wdTimeout",  timeout_err, 1);
        checkOutput("wdCmdReady", cmd_ready,   1);
        checkOutput("wdStarted",  started_cnt, 2);
        checkOutput("wdDone",     done_cnt,    0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
